// File: rtl/fft256_bitrev_reorder.sv
// fft256_bitrev_reorder: ping-pong buffer turning the bit-reversed FFT output stream into natural bin order
module fft256_bitrev_reorder #(
   parameter int WIDTH = 32,
   parameter int LOG2N = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             di_en,
   input  logic [WIDTH-1:0] di_re,
   input  logic [WIDTH-1:0] di_im,
   output logic             do_en,
   output logic [WIDTH-1:0] do_re,
   output logic [WIDTH-1:0] do_im,
   output logic [LOG2N-1:0] do_idx,
   output logic             do_first
);
   localparam int N = 1 << LOG2N;
   logic [2*WIDTH-1:0] mem [2*N];
   logic [LOG2N-1:0]   wcnt, rcnt, waddr;
   logic               wb, rbank, ract, last_write;
   for (genvar b = 0; b < LOG2N; b++) begin : g_rev
      assign waddr[b] = wcnt[LOG2N-1-b];
   end
   assign last_write = di_en && (&wcnt);
   // sample store: each incoming sample lands at the mirrored index of its arrival count
   always_ff @(posedge clock)
      if (reset && di_en) mem[{wb, waddr}] <= {di_re, di_im};
   // write counter, bank swap, reader arming and registered output stage
   always_ff @(posedge clock)
      if (!reset) begin
         wcnt     <= '0;
         wb       <= 1'b0;
         ract     <= 1'b0;
         rcnt     <= '0;
         rbank    <= 1'b0;
         do_en    <= 1'b0;
         do_first <= 1'b0;
         do_re    <= '0;
         do_im    <= '0;
         do_idx   <= '0;
      end else begin
         do_en    <= ract;
         do_first <= ract && rcnt == '0;
         if (ract) begin
            {do_re, do_im} <= mem[{rbank, rcnt}];
            do_idx         <= rcnt;
         end
         if (di_en) wcnt <= wcnt + LOG2N'(1);
         if (last_write) begin
            wb    <= ~wb;
            ract  <= 1'b1;
            rbank <= wb;
            rcnt  <= '0;
         end else if (ract) begin
            rcnt <= rcnt + LOG2N'(1);
            if (&rcnt) ract <= 1'b0;
         end
      end
endmodule

// File: tb/tb_fft256_bitrev_reorder.sv
// tb_fft256_bitrev_reorder: randomized scenario bench for the bit-reversal reorder buffer
module tb_fft256_bitrev_reorder;
   localparam int W = 32, L = 8, N = 256;
   logic clock = 1'b0, reset = 1'b0, di_en = 1'b0;
   logic [W-1:0] di_re = '0, di_im = '0;
   logic do_en, do_first;
   logic [W-1:0] do_re, do_im;
   logic [L-1:0] do_idx;
   int cyc = 0, n_vec = 0, n_err = 0;
   typedef struct {int cyc; int idx; logic [W-1:0] re; logic [W-1:0] im; logic first; logic en;} out_t;
   out_t cap[$];
   logic [W-1:0] fre[3][N], fim[3][N], ere[3][N], eim[3][N];
   int cl[3];

   fft256_bitrev_reorder #(.WIDTH(W), .LOG2N(L)) dut (
      .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
      .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_idx(do_idx), .do_first(do_first)
   );

   always #5 clock = ~clock;
   // cycle counter: value seen between edges numbers the preceding rising edge
   always @(posedge clock) cyc <= cyc + 1;
   // capture every output beat (and any stray do_first) mid-cycle
   always @(negedge clock)
      if (do_en || do_first) cap.push_back('{cyc, int'(do_idx), do_re, do_im, do_first, do_en});

   function automatic int rev(input int v);
      int r = 0;
      for (int b = 0; b < L; b++) r = (r << 1) | ((v >> b) & 1);
      return r;
   endfunction

   task automatic step(input logic en, input logic [W-1:0] re, input logic [W-1:0] im);
      di_en = en; di_re = re; di_im = im;
      @(posedge clock); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom);
   endtask

   // frame f in arrival order; natural bin rev(n) must carry arrival sample n
   task automatic load(input int f, input bit rnd, input int off);
      for (int n = 0; n < N; n++) begin
         fre[f][n] = rnd ? $urandom : n + off;
         fim[f][n] = rnd ? $urandom : 255 - n + off;
         ere[f][rev(n)] = fre[f][n];
         eim[f][rev(n)] = fim[f][n];
      end
   endtask

   // gap: 0 none, 1 alternating 1,0, 2 random 0..3 idle cycles
   task automatic send(input int f, input int gap);
      for (int n = 0; n < N; n++) begin
         step(1'b1, fre[f][n], fim[f][n]);
         if (n == N-1) cl[f] = cyc;
         else if (gap == 1) idle(1);
         else if (gap == 2) idle($urandom_range(0, 3));
      end
      di_en = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      idle(3);
      n_vec++;
      if (do_en !== 1'b0 || do_first !== 1'b0 || do_re !== '0 || do_im !== '0 || do_idx !== '0) begin
         n_err++;
         $display("FAIL reset_state: got en=%b first=%b re=%h im=%h idx=%0d, want all zero", do_en, do_first, do_re, do_im, do_idx);
      end
      reset = 1'b1;
      idle(2);
   endtask

   task automatic test_single_frame;
      int ks[3] = '{1, 2, 255};
      int kr[3] = '{128, 64, 255};
      cap.delete(); load(0, 1'b0, 0); send(0, 0); idle(270);
      n_vec++;
      if (cap.size() !== N) begin
         n_err++; $display("FAIL single_len: got %0d beats, want %0d", cap.size(), N);
      end
      for (int i = 0; i < N && i < cap.size(); i++) begin
         n_vec++;
         if (cap[i].cyc !== cl[0]+1+i || cap[i].en !== 1'b1 || cap[i].idx !== i || cap[i].first !== (i == 0) || cap[i].re !== ere[0][i] || cap[i].im !== eim[0][i]) begin
            n_err++;
            $display("FAIL single bin %0d: got cyc=%0d en=%b idx=%0d first=%b re=%h im=%h, want cyc=%0d en=1 idx=%0d first=%b re=%h im=%h",
                     i, cap[i].cyc, cap[i].en, cap[i].idx, cap[i].first, cap[i].re, cap[i].im, cl[0]+1+i, i, i == 0, ere[0][i], eim[0][i]);
         end
      end
      for (int j = 0; j < 3; j++) begin
         n_vec++;
         if (cap.size() <= ks[j] || cap[ks[j]].re !== kr[j] || cap[ks[j]].im !== 255 - kr[j]) begin
            n_err++;
            $display("FAIL spot k=%0d: got re=%0d im=%0d, want re=%0d im=%0d", ks[j],
                     cap.size() > ks[j] ? cap[ks[j]].re : 'x, cap.size() > ks[j] ? cap[ks[j]].im : 'x, kr[j], 255 - kr[j]);
         end
      end
   endtask

   task automatic test_gapped;
      for (int r = 0; r < 2; r++) begin
         cap.delete();
         load(r, r == 1, 0);
         send(r, r + 1);
         idle(270);
         n_vec++;
         if (cap.size() !== N) begin
            n_err++; $display("FAIL gapped%0d_len: got %0d beats, want %0d", r, cap.size(), N);
         end
         for (int i = 0; i < N && i < cap.size(); i++) begin
            n_vec++;
            if (cap[i].cyc !== cl[r]+1+i || cap[i].en !== 1'b1 || cap[i].idx !== i || cap[i].first !== (i == 0) || cap[i].re !== ere[r][i] || cap[i].im !== eim[r][i]) begin
               n_err++;
               $display("FAIL gapped%0d bin %0d: got cyc=%0d idx=%0d first=%b re=%h im=%h, want cyc=%0d idx=%0d first=%b re=%h im=%h",
                        r, i, cap[i].cyc, cap[i].idx, cap[i].first, cap[i].re, cap[i].im, cl[r]+1+i, i, i == 0, ere[r][i], eim[r][i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      cap.delete();
      for (int f = 0; f < 3; f++) load(f, 1'b0, 1000 * f);
      for (int f = 0; f < 3; f++) send(f, 0);
      idle(270);
      n_vec++;
      if (cap.size() !== 3*N) begin
         n_err++; $display("FAIL b2b_len: got %0d beats, want %0d", cap.size(), 3*N);
      end
      for (int i = 0; i < 3*N && i < cap.size(); i++) begin
         int f = i / N, k = i % N;
         n_vec++;
         if (cap[i].cyc !== cl[0]+1+i || cap[i].en !== 1'b1 || cap[i].idx !== k || cap[i].first !== (k == 0) || cap[i].re !== ere[f][k] || cap[i].im !== eim[f][k]) begin
            n_err++;
            $display("FAIL b2b beat %0d: got cyc=%0d idx=%0d first=%b re=%0d im=%0d, want cyc=%0d idx=%0d first=%b re=%0d im=%0d",
                     i, cap[i].cyc, cap[i].idx, cap[i].first, cap[i].re, cap[i].im, cl[0]+1+i, k, k == 0, ere[f][k], eim[f][k]);
         end
      end
   endtask

   task automatic test_reset_mid_input;
      cap.delete();
      for (int n = 0; n < 100; n++) step(1'b1, $urandom, $urandom);
      reset = 1'b0;
      idle(1);
      reset = 1'b1;
      load(0, 1'b0, 0); send(0, 0); idle(270);
      n_vec++;
      if (cap.size() !== N) begin
         n_err++; $display("FAIL midin_len: got %0d beats, want %0d", cap.size(), N);
      end
      for (int i = 0; i < N && i < cap.size(); i++) begin
         n_vec++;
         if (cap[i].cyc !== cl[0]+1+i || cap[i].idx !== i || cap[i].first !== (i == 0) || cap[i].re !== ere[0][i] || cap[i].im !== eim[0][i]) begin
            n_err++;
            $display("FAIL midin bin %0d: got cyc=%0d idx=%0d re=%h im=%h, want cyc=%0d idx=%0d re=%h im=%h",
                     i, cap[i].cyc, cap[i].idx, cap[i].re, cap[i].im, cl[0]+1+i, i, ere[0][i], eim[0][i]);
         end
      end
   endtask

   task automatic test_reset_mid_output;
      int t;
      cap.delete(); load(0, 1'b1, 0); send(0, 0);
      for (t = 0; t < 300 && !(do_en === 1'b1 && do_idx === 8'd50); t++) @(negedge clock);
      n_vec++;
      if (t >= 300) begin
         n_err++; $display("FAIL midout_wait: got no bin 50 within 300 cycles, want bin 50");
      end
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      n_vec++;
      if (do_en !== 1'b0 || do_first !== 1'b0 || do_re !== '0 || do_im !== '0 || do_idx !== '0) begin
         n_err++;
         $display("FAIL midout_zero: got en=%b first=%b re=%h im=%h idx=%0d, want all zero", do_en, do_first, do_re, do_im, do_idx);
      end
      idle(300);
      n_vec++;
      if (cap.size() !== 51) begin
         n_err++; $display("FAIL midout_len: got %0d beats, want 51", cap.size());
      end
      for (int i = 0; i < 51 && i < cap.size(); i++) begin
         n_vec++;
         if (cap[i].idx !== i || cap[i].re !== ere[0][i] || cap[i].im !== eim[0][i]) begin
            n_err++;
            $display("FAIL midout bin %0d: got idx=%0d re=%h im=%h, want idx=%0d re=%h im=%h", i, cap[i].idx, cap[i].re, cap[i].im, i, ere[0][i], eim[0][i]);
         end
      end
      cap.delete(); load(1, 1'b1, 0); send(1, 0); idle(270);
      n_vec++;
      if (cap.size() !== N) begin
         n_err++; $display("FAIL after_len: got %0d beats, want %0d", cap.size(), N);
      end
      for (int i = 0; i < N && i < cap.size(); i++) begin
         n_vec++;
         if (cap[i].cyc !== cl[1]+1+i || cap[i].idx !== i || cap[i].first !== (i == 0) || cap[i].re !== ere[1][i] || cap[i].im !== eim[1][i]) begin
            n_err++;
            $display("FAIL after bin %0d: got cyc=%0d idx=%0d re=%h im=%h, want cyc=%0d idx=%0d re=%h im=%h",
                     i, cap[i].cyc, cap[i].idx, cap[i].re, cap[i].im, cl[1]+1+i, i, ere[1][i], eim[1][i]);
         end
      end
   endtask

   task automatic test_idle;
      int bad = 0;
      reset = 1'b0;
      idle(1);
      reset = 1'b1;
      cap.delete();
      for (int i = 0; i < 1000; i++) begin
         idle(1);
         if (do_en !== 1'b0 || do_first !== 1'b0 || do_re !== '0 || do_im !== '0 || do_idx !== '0) bad++;
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++; $display("FAIL idle_outputs: got %0d non-zero cycles, want 0", bad);
      end
      n_vec++;
      if (cap.size() !== 0) begin
         n_err++; $display("FAIL idle_beats: got %0d beats, want 0", cap.size());
      end
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_gapped;
      test_back_to_back;
      test_reset_mid_input;
      test_reset_mid_output;
      test_idle;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
